// File: rtl/uart_line_buffer.sv
// Receive buffer with a case transform in front of a circular byte store, and a
// send controller that drains it to the uart until the terminator or until empty.
module uart_line_buffer #(
    parameter int         DEPTH     = 256,
    parameter int         AW        = 8,
    parameter logic [7:0] TERM      = 8'h00,
    parameter bit         AUTO_SEND = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic        btn_pressed,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    input  logic        is_transmitting,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    output logic        busy,
    output logic [AW:0] count,
    output logic        empty,
    output logic        full,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, WAIT, SEND, POP} state_t;

    state_t        state_reg, state_next;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg, count_next;
    logic          empty_reg, full_reg, overflow_reg;
    logic          btn_prev_reg, press_reg, auto_reg;
    logic [7:0]    rx_xform;
    logic          push, pop, start, last_pop;

    // mode[0] folds lowercase up, mode[1] folds uppercase down; both bits = swap.
    always_comb begin
        rx_xform = rx_byte;
        if (mode[0] && rx_byte >= 8'h61 && rx_byte <= 8'h7A)
            rx_xform = rx_byte - 8'h20;
        else if (mode[1] && rx_byte >= 8'h41 && rx_byte <= 8'h5A)
            rx_xform = rx_byte + 8'h20;
    end

    assign push     = received && !full_reg;
    assign pop      = (state_reg == POP);
    assign start    = (state_reg == IDLE) && ((press_reg && !empty_reg) || auto_reg);
    assign last_pop = (mem[rd_ptr_reg] == TERM) || (count_next == '0);

    always_comb begin
        case ({push, pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= rx_xform;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            empty_reg    <= 1'b1;
            full_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            btn_prev_reg <= 1'b0;
            press_reg    <= 1'b0;
            auto_reg     <= 1'b0;
            state_reg    <= IDLE;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg    <= count_next;
            empty_reg    <= (count_next == '0);
            full_reg     <= (count_next == (AW+1)'(DEPTH));
            btn_prev_reg <= btn_pressed;
            press_reg    <= btn_pressed && !btn_prev_reg;
            auto_reg     <= AUTO_SEND && push && (rx_xform == TERM);
            // A drop in the same cycle as a session start still leaves the flag set.
            if (start)
                overflow_reg <= 1'b0;
            if (received && full_reg)
                overflow_reg <= 1'b1;
            state_reg    <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        transmit   = 1'b0;
        case (state_reg)
            IDLE: if (start) state_next = WAIT;
            WAIT: begin
                transmit = 1'b1;
                if (is_transmitting) state_next = SEND;
            end
            SEND: if (!is_transmitting) state_next = POP;
            POP:  state_next = last_pop ? IDLE : WAIT;
            default: state_next = IDLE;
        endcase
    end

    assign tx_byte  = mem[rd_ptr_reg];
    assign busy     = (state_reg != IDLE);
    assign count    = count_reg;
    assign empty    = empty_reg;
    assign full     = full_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_line_buffer.sv
// Bench for uart_line_buffer: three parameterisations, a uart transmitter model
// and a byte scoreboard checking everything the buffer sends.
module tb_uart_line_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       btn = 1'b0;
    logic       received = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       is_tx = 1'b0;
    int         sel = 0;

    logic [2:0] transmit_v, busy_v, empty_v, full_v, ovf_v;
    logic [7:0] txb_v [3];
    logic [8:0] cnt_a;
    logic [2:0] cnt_b, cnt_c;
    logic [2:0] recv_v, btn_v, istx_v;

    logic       transmit_s, busy_s, empty_s, full_s, ovf_s;
    logic [7:0] txb_s;
    logic [8:0] count_s;

    int n_cmp = 0;
    int n_err = 0;
    int tx_cnt = 0;
    int tx_seen = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            recv_v[i] = received && (sel == i);
            btn_v[i]  = btn && (sel == i);
            istx_v[i] = is_tx && (sel == i);
        end
        transmit_s = transmit_v[sel];
        busy_s     = busy_v[sel];
        empty_s    = empty_v[sel];
        full_s     = full_v[sel];
        ovf_s      = ovf_v[sel];
        txb_s      = txb_v[sel];
        count_s    = (sel == 0) ? cnt_a : (sel == 1) ? {6'd0, cnt_b} : {6'd0, cnt_c};
    end

    uart_line_buffer dut_a (
        .clk(clk), .rst(rst), .mode(mode), .btn_pressed(btn_v[0]),
        .received(recv_v[0]), .rx_byte(rx_byte), .is_transmitting(istx_v[0]),
        .transmit(transmit_v[0]), .tx_byte(txb_v[0]), .busy(busy_v[0]),
        .count(cnt_a), .empty(empty_v[0]), .full(full_v[0]), .overflow(ovf_v[0])
    );

    uart_line_buffer #(.DEPTH(4), .AW(2), .TERM(8'h0A), .AUTO_SEND(1'b0)) dut_b (
        .clk(clk), .rst(rst), .mode(mode), .btn_pressed(btn_v[1]),
        .received(recv_v[1]), .rx_byte(rx_byte), .is_transmitting(istx_v[1]),
        .transmit(transmit_v[1]), .tx_byte(txb_v[1]), .busy(busy_v[1]),
        .count(cnt_b), .empty(empty_v[1]), .full(full_v[1]), .overflow(ovf_v[1])
    );

    uart_line_buffer #(.DEPTH(4), .AW(2), .TERM(8'h0A), .AUTO_SEND(1'b1)) dut_c (
        .clk(clk), .rst(rst), .mode(mode), .btn_pressed(btn_v[2]),
        .received(recv_v[2]), .rx_byte(rx_byte), .is_transmitting(istx_v[2]),
        .transmit(transmit_v[2]), .tx_byte(txb_v[2]), .busy(busy_v[2]),
        .count(cnt_c), .empty(empty_v[2]), .full(full_v[2]), .overflow(ovf_v[2])
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // uart transmitter model: takes a byte on transmit, stays busy 3 cycles.
    always @(negedge clk) begin
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) is_tx = 1'b0;
        end else if (transmit_s) begin
            tx_seen++;
            if (exp_q.size() == 0) begin
                check("tx_unexpected", int'(txb_s), -1);
            end else begin
                check("tx_byte", int'(txb_s), int'(exp_q.pop_front()));
            end
            $display("tx inst%0d byte %02h", sel, txb_s);
            is_tx  = 1'b1;
            tx_cnt = 3;
        end
    end

    task automatic recv(input logic [7:0] b, input logic [1:0] m, input logic [7:0] e, input bit exp_tx);
        @(negedge clk);
        received = 1'b1;
        rx_byte  = b;
        mode     = m;
        if (exp_tx) exp_q.push_back(e);
        @(negedge clk);
        received = 1'b0;
        $display("rx inst%0d byte %02h mode %0d count %0d", sel, b, m, count_s);
    endtask

    task automatic press(input bit check_lat);
        @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        if (check_lat) check("latency_1cyc_tx", int'(transmit_s), 0);
        @(negedge clk);
        if (check_lat) check("latency_2cyc_tx", int'(transmit_s), 1);
        btn = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!busy_s && n < 20) begin @(negedge clk); n++; end
        if (!busy_s) check({name, "_start_timeout"}, 0, 1);
        n = 0;
        while (busy_s && n < 2000) begin @(negedge clk); n++; end
        if (busy_s) check({name, "_end_timeout"}, 1, 0);
        n = 0;
        while (tx_cnt != 0 && n < 20) begin @(negedge clk); n++; end
        check({name, "_q_drained"}, exp_q.size(), 0);
        $display("session inst%0d %s done count %0d", sel, name, count_s);
    endtask

    typedef struct {
        logic [1:0] m;
        logic [7:0] rx;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int t0;
        int n;
        vecs[0]  = '{2'b00, 8'h61, 8'h61};
        vecs[1]  = '{2'b00, 8'h41, 8'h41};
        vecs[2]  = '{2'b01, 8'h61, 8'h41};
        vecs[3]  = '{2'b01, 8'h7A, 8'h5A};
        vecs[4]  = '{2'b01, 8'h60, 8'h60};
        vecs[5]  = '{2'b01, 8'h7B, 8'h7B};
        vecs[6]  = '{2'b01, 8'h41, 8'h41};
        vecs[7]  = '{2'b10, 8'h41, 8'h61};
        vecs[8]  = '{2'b10, 8'h5A, 8'h7A};
        vecs[9]  = '{2'b10, 8'h40, 8'h40};
        vecs[10] = '{2'b10, 8'h5B, 8'h5B};
        vecs[11] = '{2'b10, 8'h61, 8'h61};
        vecs[12] = '{2'b11, 8'h61, 8'h41};
        vecs[13] = '{2'b11, 8'h5A, 8'h7A};
        vecs[14] = '{2'b11, 8'h20, 8'h20};
        vecs[15] = '{2'b11, 8'h7A, 8'h5A};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_count_a", int'(cnt_a), 0);
        check("rst_count_b", int'(cnt_b), 0);
        check("rst_count_c", int'(cnt_c), 0);
        check("rst_busy", int'(busy_v), 0);
        check("rst_transmit", int'(transmit_v), 0);
        check("rst_empty", int'(empty_v), 7);
        check("rst_full", int'(full_v), 0);
        check("rst_overflow", int'(ovf_v), 0);

        // Transform table, drained by a terminated session.
        sel = 0;
        for (int i = 0; i < 16; i++) begin
            recv(vecs[i].rx, vecs[i].m, vecs[i].exp, 1'b1);
            check("table_count", int'(count_s), i + 1);
        end
        recv(8'h00, 2'b00, 8'h00, 1'b1);
        press(1'b1);
        wait_done("table");
        check("table_count_end", int'(count_s), 0);
        check("table_empty_end", int'(empty_s), 1);

        // Uppercase line "ab1\0".
        recv(8'h61, 2'b01, 8'h41, 1'b1);
        recv(8'h62, 2'b01, 8'h42, 1'b1);
        recv(8'h31, 2'b01, 8'h31, 1'b1);
        recv(8'h00, 2'b01, 8'h00, 1'b1);
        press(1'b0);
        wait_done("upper");
        check("upper_count", int'(count_s), 0);

        // Case swap without terminator ends on empty.
        recv(8'h41, 2'b11, 8'h61, 1'b1);
        recv(8'h7A, 2'b11, 8'h5A, 1'b1);
        press(1'b0);
        wait_done("swap");
        check("swap_empty", int'(empty_s), 1);

        // Bytes after a terminator stay for the next session.
        recv(8'h41, 2'b00, 8'h41, 1'b1);
        recv(8'h00, 2'b00, 8'h00, 1'b1);
        recv(8'h42, 2'b00, 8'h42, 1'b0);
        press(1'b0);
        wait_done("term_stop");
        check("term_stop_count", int'(count_s), 1);
        exp_q.push_back(8'h42);
        press(1'b0);
        wait_done("term_rest");
        check("term_rest_count", int'(count_s), 0);

        // Press while empty does nothing.
        t0 = tx_seen;
        press(1'b0);
        repeat (10) @(negedge clk);
        check("empty_press_tx", tx_seen - t0, 0);
        check("empty_press_busy", int'(busy_s), 0);

        // Holding the button gives exactly one session.
        recv(8'h55, 2'b00, 8'h55, 1'b1);
        recv(8'h66, 2'b00, 8'h66, 1'b1);
        t0 = tx_seen;
        @(negedge clk);
        btn = 1'b1;
        wait_done("hold");
        repeat (10) @(negedge clk);
        recv(8'h77, 2'b00, 8'h77, 1'b1);
        repeat (10) @(negedge clk);
        check("hold_tx_total", tx_seen - t0, 2);
        check("hold_count", int'(count_s), 1);
        btn = 1'b0;
        press(1'b0);
        wait_done("hold_drain");
        check("hold_drain_count", int'(count_s), 0);

        // DEPTH=4: fifth byte dropped, overflow cleared on session start.
        sel = 1;
        recv(8'h30, 2'b00, 8'h30, 1'b1);
        recv(8'h31, 2'b00, 8'h31, 1'b1);
        recv(8'h32, 2'b00, 8'h32, 1'b1);
        recv(8'h33, 2'b00, 8'h33, 1'b1);
        check("d4_full_before", int'(full_s), 1);
        check("d4_ovf_before", int'(ovf_s), 0);
        recv(8'h34, 2'b00, 8'h34, 1'b0);
        check("d4_count", int'(count_s), 4);
        check("d4_full", int'(full_s), 1);
        check("d4_overflow", int'(ovf_s), 1);
        press(1'b1);
        check("d4_ovf_cleared", int'(ovf_s), 0);
        wait_done("d4");
        check("d4_count_end", int'(count_s), 0);

        // Auto send on terminator; byte received mid-session is kept.
        sel = 2;
        recv(8'h48, 2'b00, 8'h48, 1'b1);
        recv(8'h49, 2'b00, 8'h49, 1'b1);
        recv(8'h0A, 2'b00, 8'h0A, 1'b1);
        n = 0;
        while (!busy_s && n < 10) begin @(negedge clk); n++; end
        check("auto_started", int'(busy_s), 1);
        recv(8'h4A, 2'b00, 8'h4A, 1'b0);
        wait_done("auto");
        check("auto_count", int'(count_s), 1);
        check("auto_empty", int'(empty_s), 0);
        exp_q.push_back(8'h4A);
        press(1'b0);
        wait_done("auto_rest");
        check("auto_rest_count", int'(count_s), 0);

        // Reset during SEND, with overflow pending on the small buffer.
        sel = 1;
        for (int i = 0; i < 5; i++) recv(8'h50, 2'b00, 8'h50, 1'b0);
        check("pre_rst_ovf_b", int'(ovf_s), 1);
        sel = 0;
        recv(8'h11, 2'b00, 8'h11, 1'b1);
        recv(8'h22, 2'b00, 8'h22, 1'b1);
        recv(8'h33, 2'b00, 8'h33, 1'b1);
        press(1'b0);
        n = 0;
        while (!is_tx && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        check("pre_rst_busy", int'(busy_s), 1);
        check("pre_rst_transmit", int'(transmit_s), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_transmit", int'(transmit_s), 0);
        check("rst_mid_busy", int'(busy_s), 0);
        check("rst_mid_count", int'(count_s), 0);
        check("rst_mid_ovf_b", int'(ovf_v[1]), 0);
        check("rst_mid_count_b", int'(cnt_b), 0);
        exp_q.delete();
        n = 0;
        while (tx_cnt != 0 && n < 20) begin @(negedge clk); n++; end
        recv(8'h5A, 2'b00, 8'h5A, 1'b1);
        recv(8'h5B, 2'b00, 8'h5B, 1'b1);
        press(1'b0);
        wait_done("after_rst");
        check("after_rst_count", int'(count_s), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_line_buffer.md
Name: uart_line_buffer

Overview:
- Parametrised receive-buffer/transmit controller between the uart core and the debounce block.
- Received bytes pass through a selectable case transform into a circular buffer of DEPTH bytes.
- A send session drains the buffer over the uart until a terminator byte or empty. Sessions start on a debounced button press, or automatically on terminator receipt.
- Generalises the fixed 256-byte uppercase echo: adds depth/terminator parameters, runtime mode, FIFO semantics, overflow and status.

Parameters:
- DEPTH, 256, buffer depth in bytes; power of two, 4..1024.
- AW, 8, pointer width; must equal log2(DEPTH).
- TERM, 8'h00, terminator byte that ends a send session.
- AUTO_SEND, 0, 1 = storing a TERM byte also starts a session.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  transform: 00 pass, 01 upper, 10 lower, 11 case-swap.
- btn_pressed  in  1  debounced button level.
- received  in  1  one-cycle strobe; rx_byte valid.
- rx_byte  in  8  byte from uart receiver.
- is_transmitting  in  1  uart transmitter busy.
- transmit  out  1  request uart to send tx_byte.
- tx_byte  out  8  byte at the read pointer.
- busy  out  1  send session active (state != IDLE).
- count  out  AW+1  bytes held, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky flag; a byte was dropped.

Behaviour:
- Reset (synchronous):
  - wr_ptr, rd_ptr, count = 0; state IDLE; transmit = 0; overflow = 0; button edge register = 0.
  - Memory contents are not cleared. tx_byte reflects mem[0] and is don't-care while empty.
- Transform, applied to rx_byte before storage:
  - upper: 8'h61..8'h7A -> minus 8'h20.
  - lower: 8'h41..8'h5A -> plus 8'h20.
  - swap: both rules.
  - All other bytes unchanged. mode is sampled on the received cycle.
- Push (received=1):
  - Not full: mem[wr_ptr] <= transformed byte; wr_ptr += 1, wrapping DEPTH-1 -> 0; count += 1.
  - Full: byte dropped; overflow <= 1; pointers and count unchanged.
- Pop happens only in the POP state: rd_ptr += 1 (wraps); count -= 1.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- Button edge detect:
  - Registered previous level. A press is btn_pressed=1 with the previous level 0.
  - Presses while busy or while empty are consumed and ignored.
- Session start (IDLE only):
  - On a press with empty=0.
  - Or, if AUTO_SEND=1, on the cycle after a TERM byte (post-transform) is stored.
  - On start, overflow is cleared.
- FSM states:
  - IDLE: transmit=0. On start -> WAIT next cycle.
  - WAIT: transmit=1, tx_byte=mem[rd_ptr]. is_transmitting=1 -> SEND.
  - SEND: transmit=0. Stay while is_transmitting=1; when it is 0 -> POP.
  - POP: pop one byte. -> IDLE if the popped byte == TERM or count becomes 0; else -> WAIT.
- The terminator is transmitted, then the session ends. Remaining bytes stay for the next session.
- Latency: transmit asserts 2 cycles after the press edge is seen on btn_pressed (edge register, then IDLE->WAIT).
- Reset mid-session: all state returns to reset values on that edge. transmit is 0 the following cycle. An in-flight uart byte completes but is not popped.
- count, empty and full are registered and consistent with the pointers every cycle.

Test Plan:
- Mode 01: receive "ab1\0" (61 62 31 00), press button -> transmit strobes send 41 42 31 00 in order, busy drops, count=0.
- Mode 11: receive 41 7A, press -> sends 61 5A, then IDLE with empty=1.
- Parameters DEPTH=4, TERM=8'h0A:
  - Receive 5 bytes 30..34 -> 34 dropped, full=1, overflow=1, count=4.
  - Press -> sends 30 31 32 33; overflow cleared at start.
- Parameters DEPTH=4, TERM=8'h0A, AUTO_SEND=1:
  - Receive 48 49 0A 4A -> session starts automatically, sends 48 49 0A, stops with count=1 (4A retained).
  - Receiving during SEND leaves count consistent.
- Press while empty -> no transmit. Hold the button through a session -> exactly one session.
- Assert rst while in SEND -> next cycle transmit=0, busy=0, count=0, overflow=0. A new press after refilling sends from the new data.
